// File: rtl/decode_pkg.sv
// decode_pkg: opcode encoding, instruction field positions and the ID/EX record.
// Latency: n/a; no backpressure.
package decode_pkg;

   localparam int REGI_BITS_P = 4;
   localparam int REGI_SIZE_P = 16;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_ADD   = 4'd1,
      OP_SUB   = 4'd2,
      OP_XOR   = 4'd3,
      OP_AND   = 4'd4,
      OP_ADDI  = 4'd5,
      OP_LOAD  = 4'd6,
      OP_STORE = 4'd7,
      OP_BEQ   = 4'd8,
      OP_JMP   = 4'd9
   } op_e;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 8;
   localparam int RS1_MSB = 7;
   localparam int RS1_LSB = 4;
   localparam int RS2_MSB = 3;
   localparam int RS2_LSB = 0;

   typedef struct packed {
      logic                   valid;
      logic [3:0]             op;
      logic [REGI_BITS_P-1:0] rd;
      logic [REGI_SIZE_P-1:0] a;
      logic [REGI_SIZE_P-1:0] b;
      logic [REGI_SIZE_P-1:0] sdata;
      logic [REGI_SIZE_P-1:0] pc;
   } idex_t;

   function automatic logic [REGI_SIZE_P-1:0] sext4(input logic [3:0] v);
      return {{(REGI_SIZE_P-4){v[3]}}, v};
   endfunction

   function automatic logic [REGI_SIZE_P-1:0] sext12(input logic [11:0] v);
      return {{(REGI_SIZE_P-12){v[11]}}, v};
   endfunction

endpackage

// File: rtl/regfile_16x16.sv
// regfile_16x16: 2 comb read ports, 1 write port at clk edge, R0 reads 0; WB_BYPASS_EN forwards same-cycle write data.
// Latency: reads combinational, writes visible next cycle; no backpressure.
module regfile_16x16 #(
   parameter int ABITS = 4,
   parameter int DBITS = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [ABITS-1:0] raddr_a_i,
   input  logic [ABITS-1:0] raddr_b_i,
   output logic [DBITS-1:0] rdata_a_o,
   output logic [DBITS-1:0] rdata_b_o,
   input  logic             we_i,
   input  logic [ABITS-1:0] waddr_i,
   input  logic [DBITS-1:0] wdata_i
);

   localparam int NREG = 1 << ABITS;

   logic [DBITS-1:0] regs_q [NREG];
   logic             byp_a;
   logic             byp_b;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i && (waddr_i != '0)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

`ifdef WB_BYPASS_EN
   assign byp_a = we_i && (waddr_i == raddr_a_i) && (waddr_i != '0);
   assign byp_b = we_i && (waddr_i == raddr_b_i) && (waddr_i != '0);
`else
   assign byp_a = 1'b0;
   assign byp_b = 1'b0;
`endif

   always_comb begin
      rdata_a_o = '0;
      rdata_b_o = '0;
      if (byp_a) begin
         rdata_a_o = wdata_i;
      end else if (raddr_a_i != '0) begin
         rdata_a_o = regs_q[raddr_a_i];
      end
      if (byp_b) begin
         rdata_b_o = wdata_i;
      end else if (raddr_b_i != '0) begin
         rdata_b_o = regs_q[raddr_b_i];
      end
   end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: decode, regfile read, load-use stall, branch/jump redirect + squash, ID/EX register (WB_BYPASS_EN in regfile).
// Latency: 1 cycle to ex_*; stall_o holds fetch for one cycle per load-use hazard.
module decode_stage
   import decode_pkg::*;
#(
   parameter int REGI_BITS = 4,
   parameter int REGI_SIZE = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [REGI_SIZE-1:0] next_pc_i,
   input  logic [REGI_SIZE-1:0] instr_i,
   input  logic                 wb_en_i,
   input  logic [REGI_BITS-1:0] wb_addr_i,
   input  logic [REGI_SIZE-1:0] wb_data_i,
   output logic                 stall_o,
   output logic                 redirect_o,
   output logic [REGI_SIZE-1:0] redirect_pc_o,
   output logic                 ex_valid_o,
   output logic [3:0]           ex_op_o,
   output logic [REGI_BITS-1:0] ex_rd_o,
   output logic [REGI_SIZE-1:0] ex_a_o,
   output logic [REGI_SIZE-1:0] ex_b_o,
   output logic [REGI_SIZE-1:0] ex_sdata_o,
   output logic [REGI_SIZE-1:0] ex_pc_o
);

   logic [3:0]           op;
   logic [REGI_BITS-1:0] rd;
   logic [REGI_BITS-1:0] rs1;
   logic [REGI_BITS-1:0] rs2;
   logic [REGI_BITS-1:0] raddr_b;
   logic [REGI_SIZE-1:0] rdata_a;
   logic [REGI_SIZE-1:0] rdata_b;
   logic [REGI_SIZE-1:0] target;

   logic is_alu, op_valid, uses_rs1, uses_rs2, uses_rd;
   logic hazard, taken, quiet;

   idex_t idex_q, idex_d, dec;
   logic  squash_q, squash_d;
   logic  post_rst_q;

   assign op  = instr_i[OP_MSB:OP_LSB];
   assign rd  = instr_i[RD_MSB:RD_LSB];
   assign rs1 = instr_i[RS1_MSB:RS1_LSB];
   assign rs2 = instr_i[RS2_MSB:RS2_LSB];

   assign is_alu   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR) || (op == OP_AND);
   assign op_valid = (op >= OP_ADD) && (op <= OP_JMP);
   assign uses_rs1 = is_alu || (op == OP_ADDI) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BEQ);
   assign uses_rs2 = is_alu;
   assign uses_rd  = (op == OP_STORE) || (op == OP_BEQ);

   // Port B carries rs2 for ALU ops, otherwise rd (store data / BEQ compare).
   assign raddr_b = is_alu ? rs2 : rd;

   regfile_16x16 #(
      .ABITS(REGI_BITS),
      .DBITS(REGI_SIZE)
   ) u_rf (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .raddr_a_i (rs1),
      .raddr_b_i (raddr_b),
      .rdata_a_o (rdata_a),
      .rdata_b_o (rdata_b),
      .we_i      (wb_en_i),
      .waddr_i   (wb_addr_i),
      .wdata_i   (wb_data_i)
   );

   always_comb begin
      dec = '0;
      if (op_valid) begin
         dec.valid = 1'b1;
         dec.op    = op;
         dec.rd    = rd;
         dec.a     = rdata_a;
         dec.pc    = next_pc_i;
         if (is_alu) begin
            dec.b = rdata_b;
         end else if (op == OP_ADDI) begin
            dec.b = sext4(rs2);
         end
         if (op == OP_STORE) begin
            dec.sdata = rdata_b;
         end
      end
   end

   always_comb begin
      hazard = 1'b0;
      if (idex_q.valid && (idex_q.op == OP_LOAD) && (idex_q.rd != '0)) begin
         hazard = (uses_rs1 && (idex_q.rd == rs1)) ||
                  (uses_rs2 && (idex_q.rd == rs2)) ||
                  (uses_rd  && (idex_q.rd == rd));
      end
   end

   assign taken  = ((op == OP_BEQ) && (rdata_a == rdata_b)) || (op == OP_JMP);
   assign target = (op == OP_JMP) ? next_pc_i + sext12(instr_i[11:0])
                                  : next_pc_i + sext4(rs2);

   // Reset, the cycle right after it, and a squashed slot never stall or redirect.
   assign quiet         = rst_i || post_rst_q || squash_q;
   assign stall_o       = !quiet && hazard;
   assign redirect_o    = !quiet && !hazard && taken;
   assign redirect_pc_o = redirect_o ? target : '0;

   always_comb begin
      idex_d   = dec;
      squash_d = redirect_o;
      if (squash_q || stall_o) begin
         idex_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idex_q     <= '0;
         squash_q   <= 1'b0;
         post_rst_q <= 1'b1;
      end else begin
         idex_q     <= idex_d;
         squash_q   <= squash_d;
         post_rst_q <= 1'b0;
      end
   end

   assign ex_valid_o = idex_q.valid;
   assign ex_op_o    = idex_q.op;
   assign ex_rd_o    = idex_q.rd;
   assign ex_a_o     = idex_q.a;
   assign ex_b_o     = idex_q.b;
   assign ex_sdata_o = idex_q.sdata;
   assign ex_pc_o    = idex_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors into decode_stage; expected outputs queued at issue and checked by a monitor.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] next_pc = '0;
   logic [15:0] instr = '0;
   logic        wb_en = 1'b0;
   logic [3:0]  wb_addr = '0;
   logic [15:0] wb_data = '0;
   logic        stall, redirect;
   logic [15:0] redirect_pc;
   logic        ex_valid;
   logic [3:0]  ex_op, ex_rd;
   logic [15:0] ex_a, ex_b, ex_sdata, ex_pc;

   decode_stage dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .next_pc_i     (next_pc),
      .instr_i       (instr),
      .wb_en_i       (wb_en),
      .wb_addr_i     (wb_addr),
      .wb_data_i     (wb_data),
      .stall_o       (stall),
      .redirect_o    (redirect),
      .redirect_pc_o (redirect_pc),
      .ex_valid_o    (ex_valid),
      .ex_op_o       (ex_op),
      .ex_rd_o       (ex_rd),
      .ex_a_o        (ex_a),
      .ex_b_o        (ex_b),
      .ex_sdata_o    (ex_sdata),
      .ex_pc_o       (ex_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic        v;
      logic [3:0]  op;
      logic [3:0]  rd;
      logic [15:0] a, b, sd, pc;
   } ex_t;

   typedef struct {
      int          due;
      logic        st;
      logic        rdr;
      logic [15:0] rpc;
   } cb_t;

   ex_t exq[$];
   cb_t cbq[$];
   int  cyc = 0;
   int  tests = 0;
   int  fails = 0;

`ifdef WB_BYPASS_EN
   localparam logic [15:0] BYP_R1 = 16'd7;
`else
   localparam logic [15:0] BYP_R1 = 16'd0;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      cb_t c;
      ex_t e;
      if (cbq.size() > 0 && cbq[0].due <= cyc) begin
         c = cbq.pop_front();
         tests++;
         if (c.due != cyc || stall !== c.st || redirect !== c.rdr || redirect_pc !== c.rpc) begin
            fails++;
            $display("FAIL comb@%0d: got stall=%b redir=%b rpc=%h, need stall=%b redir=%b rpc=%h",
                     c.due, stall, redirect, redirect_pc, c.st, c.rdr, c.rpc);
         end
      end
      if (exq.size() > 0 && exq[0].due <= cyc) begin
         e = exq.pop_front();
         tests++;
         if (e.due != cyc || ex_valid !== e.v || ex_op !== e.op || ex_rd !== e.rd ||
             ex_a !== e.a || ex_b !== e.b || ex_sdata !== e.sd || ex_pc !== e.pc) begin
            fails++;
            $display("FAIL idex@%0d: got v=%b op=%h rd=%h a=%h b=%h sd=%h pc=%h, need v=%b op=%h rd=%h a=%h b=%h sd=%h pc=%h",
                     e.due, ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_sdata, ex_pc,
                     e.v, e.op, e.rd, e.a, e.b, e.sd, e.pc);
         end
      end
   end

   // One cycle of stimulus: inputs, expected comb outputs now, expected ID/EX next cycle.
   task automatic step(input logic r, input logic [15:0] ins, input logic [15:0] npc,
                       input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic es, input logic er, input logic [15:0] erpc,
                       input logic ev, input logic [3:0] eop, input logic [3:0] erd,
                       input logic [15:0] ea, input logic [15:0] eb,
                       input logic [15:0] esd, input logic [15:0] epc);
      cb_t c;
      ex_t e;
      @(posedge clk);
      #1;
      rst = r; instr = ins; next_pc = npc;
      wb_en = we; wb_addr = wa; wb_data = wd;
      c.due = cyc; c.st = es; c.rdr = er; c.rpc = erpc;
      e.due = cyc + 1; e.v = ev; e.op = eop; e.rd = erd;
      e.a = ea; e.b = eb; e.sd = esd; e.pc = epc;
      cbq.push_back(c);
      exq.push_back(e);
   endtask

   task automatic bubble(input logic r, input logic [15:0] ins, input logic [15:0] npc,
                         input logic we, input logic [3:0] wa, input logic [15:0] wd,
                         input logic es);
      step(r, ins, npc, we, wa, wd, es, 1'b0, 16'h0, 1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
   endtask

   initial begin
      bubble(1, 16'h1312, 16'h0, 0, 4'h0, 16'h0, 0);
      bubble(1, 16'h1312, 16'h0, 0, 4'h0, 16'h0, 0);
      bubble(0, 16'h0000, 16'h0, 1, 4'h1, 16'd5, 0);
      bubble(0, 16'h0000, 16'h0, 1, 4'h2, 16'd3, 0);
      // ADD / ADDI
      step(0, 16'h1312, 16'h0005, 0, 0, 0, 0, 0, 0, 1, 4'h1, 4'h3, 16'd5, 16'd3, 0, 16'h0005);
      step(0, 16'h541F, 16'h0006, 0, 0, 0, 0, 0, 0, 1, 4'h5, 4'h4, 16'd5, 16'hFFFF, 0, 16'h0006);
      // load-use on rs1
      step(0, 16'h6510, 16'h0007, 0, 0, 0, 0, 0, 0, 1, 4'h6, 4'h5, 16'd5, 0, 0, 16'h0007);
      bubble(0, 16'h1652, 16'h0008, 0, 0, 0, 1);
      step(0, 16'h1652, 16'h0008, 0, 0, 0, 0, 0, 0, 1, 4'h1, 4'h6, 16'd0, 16'd3, 0, 16'h0008);
      // load-use on rs2
      step(0, 16'h6510, 16'h0009, 0, 0, 0, 0, 0, 0, 1, 4'h6, 4'h5, 16'd5, 0, 0, 16'h0009);
      bubble(0, 16'h1625, 16'h000A, 0, 0, 0, 1);
      step(0, 16'h1625, 16'h000A, 0, 0, 0, 0, 0, 0, 1, 4'h1, 4'h6, 16'd3, 16'd0, 0, 16'h000A);
      // untaken BEQ (R1=5, R2=3)
      step(0, 16'h8122, 16'h0010, 0, 0, 0, 0, 0, 0, 1, 4'h8, 4'h1, 16'd3, 0, 0, 16'h0010);
      bubble(0, 16'h0000, 16'h0, 1, 4'h1, 16'd0, 0);
      bubble(0, 16'h0000, 16'h0, 1, 4'h2, 16'd0, 0);
      // taken BEQ then squashed slot
      step(0, 16'h8122, 16'h0010, 0, 0, 0, 0, 1, 16'h0012, 1, 4'h8, 4'h1, 0, 0, 0, 16'h0010);
      bubble(0, 16'h1312, 16'h0011, 0, 0, 0, 0);
      step(0, 16'h1312, 16'h0013, 0, 0, 0, 0, 0, 0, 1, 4'h1, 4'h3, 0, 0, 0, 16'h0013);
      // hazarded BEQ waits, then resolves
      step(0, 16'h6310, 16'h0020, 0, 0, 0, 0, 0, 0, 1, 4'h6, 4'h3, 0, 0, 0, 16'h0020);
      bubble(0, 16'h8312, 16'h0021, 0, 0, 0, 1);
      step(0, 16'h8312, 16'h0021, 0, 0, 0, 0, 1, 16'h0023, 1, 4'h8, 4'h3, 0, 0, 0, 16'h0021);
      bubble(0, 16'h1312, 16'h0022, 0, 0, 0, 0);
      // JMP wrap, then reset during its squash cycle
      step(0, 16'h9FFF, 16'h0000, 0, 0, 0, 0, 1, 16'hFFFF, 1, 4'h9, 4'hF, 0, 0, 0, 16'h0000);
      bubble(1, 16'h1312, 16'h0023, 0, 0, 0, 0);
      step(0, 16'h1312, 16'h0030, 0, 0, 0, 0, 0, 0, 1, 4'h1, 4'h3, 0, 0, 0, 16'h0030);
      // same-cycle write-back and read of R1
      step(0, 16'h1312, 16'h0031, 1, 4'h1, 16'd7, 0, 0, 0, 1, 4'h1, 4'h3, BYP_R1, 0, 0, 16'h0031);
      step(0, 16'h1312, 16'h0032, 0, 0, 0, 0, 0, 0, 1, 4'h1, 4'h3, 16'd7, 0, 0, 16'h0032);
      // STORE data, R0 write ignored, undefined opcode
      bubble(0, 16'h0000, 16'h0, 1, 4'h2, 16'd9, 0);
      step(0, 16'h7210, 16'h0040, 0, 0, 0, 0, 0, 0, 1, 4'h7, 4'h2, 16'd7, 0, 16'd9, 16'h0040);
      bubble(0, 16'h0000, 16'h0, 1, 4'h0, 16'h0055, 0);
      step(0, 16'h1300, 16'h0050, 0, 0, 0, 0, 0, 0, 1, 4'h1, 4'h3, 0, 0, 0, 16'h0050);
      bubble(0, 16'hA123, 16'h0051, 0, 0, 0, 0);
      bubble(0, 16'h0000, 16'h0, 0, 0, 0, 0);
      for (int i = 0; i < 10 && (exq.size() > 0 || cbq.size() > 0); i++) begin
         @(posedge clk);
      end
      @(negedge clk);
      #1;
      if (exq.size() > 0 || cbq.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d idex and %0d comb checks left, need 0", exq.size(), cbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
